// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between the display
// scan-out (fixed read slots every 2**SCALE_LOG2 pixels) and a small write
// FIFO fed by the image producer. Reads always win; writes drain in the gaps.
module fb_arbiter #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        display_en,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_sof,
  output logic        wr_ready,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        img_done
);

  localparam int AW = 15;
  localparam int EW = AW + 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] W_VEC     = AW'(IMG_W);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  // row * IMG_W as a sum of shifted copies, one per set bit of the constant
  function automatic logic [AW-1:0] mul_w(input logic [AW-1:0] r);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < AW; i++)
      if (W_VEC[i]) acc = acc + (r << i);
    return acc;
  endfunction

  // FIFO entry layout: {addr[14:0], data[7:0]}
  logic [EW-1:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_idx_q, wr_idx_d;
  logic [PW-1:0]   rd_idx_q, rd_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [1:0]      vld_pipe_q;
  logic            rd_vld_q;
  logic [7:0]      pix_q;
  logic            img_done_q;

  logic            read_slot;
  logic            fifo_empty;
  logic            push, pop;
  logic [EW-1:0]   head;
  logic [EW-1:0]   new_entry;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   row, col;

  // wr_ready looks only at the current count, so a pop this cycle does not
  // free a slot until the next one
  assign wr_ready = (count_q != FULL_CNT);

  // Slot decode, read address, and RAM port mux (read > write > idle)
  always_comb begin
    read_slot  = display_en && (h_count[SCALE_LOG2-1:0] == '0);
    fifo_empty = (count_q == '0);
    push       = !reset && wr_valid && wr_ready;
    pop        = !reset && !read_slot && !fifo_empty;
    head       = fifo_q[rd_idx_q];
    row        = AW'(v_count >> SCALE_LOG2);
    col        = AW'(h_count >> SCALE_LOG2);
    rd_addr    = mul_w(row) + col;
    new_entry  = {(wr_sof ? '0 : wptr_q), wr_data};
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset) begin
      if (read_slot) begin
        mem_addr = rd_addr;
      end else if (!fifo_empty) begin
        mem_we    = 1'b1;
        mem_addr  = head[EW-1:8];
        mem_wdata = head[7:0];
      end
    end
  end

  // FIFO pointer/count and image write-pointer next state
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    if (push) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_sof)                 wptr_d = AW'(1);
      else if (wptr_q == LAST_ADDR) wptr_d = '0;
      else                        wptr_d = wptr_q + 1'b1;
    end
    if (pop) rd_idx_d = rd_idx_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_idx_q] <= new_entry;
  end

  // Control state, display pipeline and end-of-image pulse
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      vld_pipe_q <= '0;
      rd_vld_q   <= 1'b0;
      pix_q      <= '0;
      img_done_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      vld_pipe_q <= {vld_pipe_q[0], display_en};
      rd_vld_q   <= read_slot;
      // RAM data for a read slot lands one cycle later; capture and hold it
      if (rd_vld_q) pix_q <= mem_rdata;
      img_done_q <= mem_we && (mem_addr == LAST_ADDR);
    end
  end

  assign pix_valid = vld_pipe_q[1];
  assign pix_data  = pix_valid ? pix_q : 8'h00;
  assign img_done  = img_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        display_en;
  logic [9:0]  h_count, v_count;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_sof;
  logic        wr_ready;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        img_done;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] ram [0:32767];

  fb_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .display_en(display_en),
    .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_sof(wr_sof), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .img_done(img_done)
  );

  always #5 clk_sys = ~clk_sys;

  // single-port RAM, read data one cycle after the address
  always @(posedge clk_sys) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; display_en = 1'b0; h_count = '0; v_count = '0;
    wr_valid = 1'b1; wr_data = 8'h55; wr_sof = 1'b1;
    step();
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_during got %b want 0", mem_we); end
    step();
    reset = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, wr_ready, pix_valid, pix_data, img_done} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_release got we=%b rdy=%b pv=%b pd=%h done=%b want 0 1 0 00 0",
               mem_we, wr_ready, pix_valid, pix_data, img_done);
    end
    step();
    #1;
    n_tests++;
    if ({mem_we, mem_addr} !== {1'b0, 15'd0}) begin
      n_fail++; $display("FAIL rst_no_push got we=%b addr=%0d want 0 0", mem_we, mem_addr);
    end
  endtask

  task automatic test_blank_writes();
    step();
    display_en = 1'b0; wr_valid = 1'b1; wr_data = 8'hAA; wr_sof = 1'b1;
    #1;
    n_tests++;
    if ({mem_we, wr_ready} !== 2'b01) begin
      n_fail++; $display("FAIL blank_idle got we=%b rdy=%b want 0 1", mem_we, wr_ready);
    end
    step();
    wr_data = 8'hBB; wr_sof = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd0, 8'hAA}) begin
      n_fail++; $display("FAIL blank_w0 got we=%b a=%0d d=%h want 1 0 aa", mem_we, mem_addr, mem_wdata);
    end
    step();
    wr_data = 8'hCC;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd1, 8'hBB}) begin
      n_fail++; $display("FAIL blank_w1 got we=%b a=%0d d=%h want 1 1 bb", mem_we, mem_addr, mem_wdata);
    end
    step();
    wr_valid = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd2, 8'hCC}) begin
      n_fail++; $display("FAIL blank_w2 got we=%b a=%0d d=%h want 1 2 cc", mem_we, mem_addr, mem_wdata);
    end
    step();
    #1;
    n_tests++;
    if ({mem_we, mem_addr} !== {1'b0, 15'd0}) begin
      n_fail++; $display("FAIL blank_empty got we=%b a=%0d want 0 0", mem_we, mem_addr);
    end
  endtask

  task automatic test_read_slot();
    logic [7:0] exp_pd [0:4];
    ram[162] = 8'h5A;
    ram[163] = 8'h77;
    step();
    display_en = 1'b0; wr_valid = 1'b1; wr_data = 8'hDD; wr_sof = 1'b0;
    step();
    // read slot with a write pending: read wins
    wr_valid = 1'b0; display_en = 1'b1; h_count = 10'd8; v_count = 10'd4;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, pix_valid, pix_data} !== {1'b0, 15'd162, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rd_slot got we=%b a=%0d pv=%b pd=%h want 0 162 0 00",
                         mem_we, mem_addr, pix_valid, pix_data);
    end
    step();
    h_count = 10'd9;
    #1;
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd3, 8'hDD}) begin
      n_fail++; $display("FAIL rd_deferred_wr got we=%b a=%0d d=%h want 1 3 dd", mem_we, mem_addr, mem_wdata);
    end
    // pix_data: 5A for four cycles, then 77 from the h=12 slot
    exp_pd[0] = 8'h5A; exp_pd[1] = 8'h5A; exp_pd[2] = 8'h5A; exp_pd[3] = 8'h5A; exp_pd[4] = 8'h77;
    for (int k = 0; k < 5; k++) begin
      step();
      h_count = 10'(10 + k);
      #1;
      n_tests++;
      if ({pix_valid, pix_data} !== {1'b1, exp_pd[k]}) begin
        n_fail++; $display("FAIL rd_pix_%0d got pv=%b pd=%h want 1 %h", k, pix_valid, pix_data, exp_pd[k]);
      end
    end
    step();
    display_en = 1'b0; h_count = '0; v_count = '0;
    step();
    step();
    #1;
    n_tests++;
    if ({pix_valid, pix_data} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rd_pix_blank got pv=%b pd=%h want 0 00", pix_valid, pix_data);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    // hold a read slot every cycle so nothing drains
    for (int k = 0; k < 4; k++) begin
      step();
      display_en = 1'b1; h_count = '0; v_count = '0;
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'(8'h10 + k);
      #1;
      n_tests++;
      if ({wr_ready, mem_we} !== 2'b10) begin
        n_fail++; $display("FAIL full_fill_%0d got rdy=%b we=%b want 1 0", k, wr_ready, mem_we);
      end
    end
    step();
    wr_data = 8'h14;
    #1;
    n_tests++;
    if ({wr_ready, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL full_ready got rdy=%b we=%b want 0 0", wr_ready, mem_we);
    end
    step();
    #1;
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_hold got rdy=%b want 0", wr_ready);
    end
    step();
    display_en = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      #1;
      d = 8'(8'h10 + k);
      n_tests++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'(4 + k), d}) begin
        n_fail++; $display("FAIL full_drain_%0d got we=%b a=%0d d=%h want 1 %0d %h",
                           k, mem_we, mem_addr, mem_wdata, 4 + k, d);
      end
      if (k == 0) #0;
    end
    step();
    #1;
    n_tests++;
    if ({mem_we, wr_ready} !== 2'b01) begin
      n_fail++; $display("FAIL full_no_fifth got we=%b rdy=%b want 0 1", mem_we, wr_ready);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    int done_cnt = 0;
    int done_at = -1;
    int exp_a;
    logic [7:0] exp_d;
    for (int i = 0; i <= 19201; i++) begin
      step();
      display_en = 1'b0;
      wr_valid = (i <= 19200);
      wr_sof   = (i == 0);
      wr_data  = (i == 19200) ? 8'hE7 : 8'(i);
      #1;
      if (img_done === 1'b1) begin done_cnt++; done_at = i; end
      if (i >= 1) begin
        exp_a = (i - 1) % 19200;
        exp_d = (i - 1 == 19200) ? 8'hE7 : 8'(i - 1);
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'(exp_a), exp_d}) bad++;
      end
      if (i == 19201) begin
        n_tests++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd0, 8'hE7}) begin
          n_fail++; $display("FAIL stream_wrap got we=%b a=%0d d=%h want 1 0 e7", mem_we, mem_addr, mem_wdata);
        end
      end
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
    step();
    #1;
    if (img_done === 1'b1) done_cnt++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stream_writes got %0d bad cycles want 0", bad); end
    n_tests++;
    if (done_cnt != 1 || done_at != 19201) begin
      n_fail++; $display("FAIL stream_img_done got count=%0d at=%0d want 1 19201", done_cnt, done_at);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      display_en = 1'b1; h_count = '0; v_count = '0;
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'(8'h31 + k);
    end
    step();
    wr_valid = 1'b0; display_en = 1'b0; reset = 1'b1;
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_in_reset got %b want 0", mem_we); end
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, wr_ready, pix_valid, pix_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rmid_release got we=%b rdy=%b pv=%b pd=%h want 0 1 0 00",
                         mem_we, wr_ready, pix_valid, pix_data);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      if (mem_we !== 1'b0) stray++;
    end
    n_tests++;
    if (stray != 0) begin n_fail++; $display("FAIL rmid_stray_writes got %0d want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_blank_writes();
    test_read_slot();
    test_fifo_full();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
